// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic result collector slice.
// Combinational helpers only; no state, no handshake.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } coll_state_t;

   localparam int MAC_NUM_DEF = 10;
   localparam int BW_ACT_DEF  = 8;
   localparam int BW_ACCU_DEF = 32;

   function automatic longint sat_hi(input int bw);
      return (longint'(1) << (bw - 1)) - 1;
   endfunction

   function automatic longint sat_lo(input int bw);
      return -(longint'(1) << (bw - 1));
   endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Partial-sum input stream, frame control and packed result vector handshake.
// master drives psums/start/out_ready; slave is the collector.
interface systolic_result_collector_if
   import systolic_pkg::*;
#(
   parameter int MAC_NUM = MAC_NUM_DEF,
   parameter int BW_ACT  = BW_ACT_DEF,
   parameter int BW_ACCU = BW_ACCU_DEF
);

   logic                      start;
   logic [7:0]                shift_num;
   logic                      psum_valid;
   logic signed [BW_ACCU-1:0] psum_in;
   logic signed [BW_ACT-1:0]  out_vec [MAC_NUM];
   logic                      out_valid;
   logic                      out_ready;
   logic                      busy;
   logic                      sat_flag;

   modport master (
      output start, shift_num, psum_valid, psum_in, out_ready,
      input  out_vec, out_valid, busy, sat_flag
   );

   modport slave (
      input  start, shift_num, psum_valid, psum_in, out_ready,
      output out_vec, out_valid, busy, sat_flag
   );

endinterface

// File: rtl/systolic_requant.sv
// Rounding arithmetic right shift (half toward +inf) then saturation to BW_ACT bits.
// Purely combinational, no backpressure.
module systolic_requant
   import systolic_pkg::*;
#(
   parameter int BW_ACT  = BW_ACT_DEF,
   parameter int BW_ACCU = BW_ACCU_DEF,
   parameter int SHIFT_W = 8
) (
   input  logic signed [BW_ACCU-1:0] psum,
   input  logic [SHIFT_W-1:0]        shift,
   output logic signed [BW_ACT-1:0]  res,
   output logic                      sat
);

   localparam int SW = $clog2(BW_ACCU);
   localparam logic signed [BW_ACCU:0] HI = (BW_ACCU+1)'(sat_hi(BW_ACT));
   localparam logic signed [BW_ACCU:0] LO = (BW_ACCU+1)'(sat_lo(BW_ACT));

   logic [SW-1:0]           s;
   logic signed [BW_ACCU:0] ext;
   logic signed [BW_ACCU:0] rnd;
   logic signed [BW_ACCU:0] r;

   // One extra bit of headroom so adding the rounding half never wraps.
   always_comb begin
      s   = (shift > SHIFT_W'(BW_ACCU - 1)) ? SW'(BW_ACCU - 1) : SW'(shift);
      ext = {psum[BW_ACCU-1], psum};
      rnd = (BW_ACCU+1)'(1) << (s - SW'(1));
      r   = (s == '0) ? ext : ((ext + rnd) >>> s);
      sat = 1'b0;
      res = r[BW_ACT-1:0];
      if (r > HI) begin
         res = HI[BW_ACT-1:0];
         sat = 1'b1;
      end else if (r < LO) begin
         res = LO[BW_ACT-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/systolic_result_collector.sv
// Packs MAC_NUM requantized psums into one vector; element write latency 1 cycle.
// Vector is held (psums dropped) until out_ready; start in the accept cycle chains frames.
module systolic_result_collector
   import systolic_pkg::*;
#(
   parameter int MAC_NUM = MAC_NUM_DEF,
   parameter int BW_ACT  = BW_ACT_DEF,
   parameter int BW_ACCU = BW_ACCU_DEF
) (
   input logic clk,
   input logic reset,
   systolic_result_collector_if.slave bus
);

   localparam int IDX_W = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(MAC_NUM - 1);

   coll_state_t              state_q;
   coll_state_t              state_d;
   logic [IDX_W-1:0]         idx_q;
   logic [7:0]               shift_q;
   logic                     sat_q;
   logic                     start_acc;
   logic                     capture;
   logic signed [BW_ACT-1:0] rq_val;
   logic                     rq_sat;
   logic signed [BW_ACT-1:0] vec_q [MAC_NUM];

   systolic_requant #(
      .BW_ACT  (BW_ACT),
      .BW_ACCU (BW_ACCU),
      .SHIFT_W (8)
   ) u_requant (
      .psum  (bus.psum_in),
      .shift (shift_q),
      .res   (rq_val),
      .sat   (rq_sat)
   );

   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               start_acc = 1'b1;
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            if (bus.psum_valid) begin
               capture = 1'b1;
               if (idx_q == LAST) state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               if (bus.start) begin
                  start_acc = 1'b1;
                  state_d   = COLLECT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Vector is never cleared between frames; a new frame simply overwrites it.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         shift_q <= '0;
         sat_q   <= 1'b0;
         for (int i = 0; i < MAC_NUM; i++) vec_q[i] <= '0;
      end else if (start_acc) begin
         shift_q <= bus.shift_num;
         idx_q   <= '0;
         sat_q   <= 1'b0;
      end else if (capture) begin
         vec_q[idx_q] <= rq_val;
         idx_q        <= (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
         sat_q        <= sat_q | rq_sat;
      end
   end

   assign bus.out_vec   = vec_q;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Scoreboard bench for systolic_result_collector: expected elements queued as psums are driven.
`timescale 1ns/1ps
module tb_systolic_result_collector;

   localparam int MAC_NUM = 10;
   localparam int BW_ACT  = 8;
   localparam int BW_ACCU = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   systolic_result_collector_if #(.MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_ACCU(BW_ACCU)) bus ();

   systolic_result_collector #(.MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .BW_ACCU(BW_ACCU)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic signed [BW_ACT-1:0] sb [$];
   int cur_shift = 0;
   bit exp_sat   = 1'b0;

   function automatic longint model_rq(input longint p, input int sh);
      int s;
      s = (sh > 31) ? 31 : sh;
      if (s == 0) return p;
      return (p + (longint'(1) << (s - 1))) >>> s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int sh);
      bus.start     = 1'b1;
      bus.shift_num = 8'(sh);
      tick();
      bus.start = 1'b0;
      cur_shift = sh;
      exp_sat   = 1'b0;
   endtask

   task automatic send_psum(input longint v);
      longint r;
      r = model_rq(v, cur_shift);
      if (r > 127) begin
         r = 127;
         exp_sat = 1'b1;
      end else if (r < -128) begin
         r = -128;
         exp_sat = 1'b1;
      end
      sb.push_back(BW_ACT'(r));
      bus.psum_valid = 1'b1;
      bus.psum_in    = BW_ACCU'(v);
      tick();
      bus.psum_valid = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.shift_num = '0; bus.psum_valid = 1'b0;
      bus.psum_in = '0; bus.out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.sat_flag !== 1'b0) $display("FAIL reset_sat_flag: got %b expected 0", bus.sat_flag);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         total_cnt++;
         if (bus.out_vec[i] !== '0) $display("FAIL reset_vec[%0d]: got %0d expected 0", i, bus.out_vec[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_basic();
      longint vals [MAC_NUM] = '{100, -100, 8, -8, 0, 7, 1, 2, 3, -9};
      int fixed [6] = '{6, -6, 1, 0, 0, 0};
      logic signed [BW_ACT-1:0] e;
      do_start(4);
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL basic_busy_after_start: got %b expected 1", bus.busy);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         send_psum(vals[i]);
         if (i == MAC_NUM - 2) begin
            total_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL basic_valid_latency: got %b expected 1", bus.out_valid);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         total_cnt++;
         if (bus.out_vec[i] !== BW_ACT'(fixed[i]))
            $display("FAIL basic_fixed[%0d]: got %0d expected %0d", i, bus.out_vec[i], fixed[i]);
         else pass_cnt++;
      end
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL basic_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      total_cnt++;
      if (bus.sat_flag !== 1'b0) $display("FAIL basic_sat: got %b expected 0", bus.sat_flag);
      else pass_cnt++;
      accept();
      total_cnt++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL basic_release: got valid=%b busy=%b expected 0/0", bus.out_valid, bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      bit ok;
      logic signed [BW_ACT-1:0] e;
      do_start(4);
      send_psum(5000);
      send_psum(-5000);
      for (int i = 2; i < MAC_NUM; i++) send_psum(16);
      wait_valid(ok);
      total_cnt++;
      if (!ok) $display("FAIL sat_timeout: got no out_valid expected out_valid");
      else pass_cnt++;
      total_cnt++;
      if (bus.out_vec[0] !== 8'sd127) $display("FAIL sat_pos: got %0d expected 127", bus.out_vec[0]);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_vec[1] !== -8'sd128) $display("FAIL sat_neg: got %0d expected -128", bus.out_vec[1]);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL sat_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      total_cnt++;
      if (bus.sat_flag !== exp_sat) $display("FAIL sat_flag_set: got %b expected %b", bus.sat_flag, exp_sat);
      else pass_cnt++;
      accept();
      total_cnt++;
      if (bus.sat_flag !== 1'b1) $display("FAIL sat_sticky_idle: got %b expected 1", bus.sat_flag);
      else pass_cnt++;
      do_start(4);
      total_cnt++;
      if (bus.sat_flag !== 1'b0) $display("FAIL sat_clear_on_start: got %b expected 0", bus.sat_flag);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) send_psum(longint'(i * 37 - 150));
      wait_valid(ok);
      total_cnt++;
      if (!ok) $display("FAIL sat2_timeout: got no out_valid expected out_valid");
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL sat2_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      total_cnt++;
      if (bus.sat_flag !== 1'b0) $display("FAIL sat2_flag: got %b expected 0", bus.sat_flag);
      else pass_cnt++;
      accept();
   endtask

   task automatic test_shift_edges();
      longint v0 [MAC_NUM] = '{42, -128, 127, -5, 0, 1, -1, 100, -100, 64};
      longint v1 [4] = '{longint'(1) << 30, -(longint'(1) << 31), (longint'(1) << 31) - 1, -1};
      bit ok;
      logic signed [BW_ACT-1:0] e;
      do_start(0);
      for (int i = 0; i < MAC_NUM; i++) send_psum(v0[i]);
      wait_valid(ok);
      total_cnt++;
      if (bus.out_vec[0] !== 8'sd42 || !ok) $display("FAIL shift0_42: got %0d ok=%b expected 42", bus.out_vec[0], ok);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL shift0_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      accept();
      do_start(40);
      for (int i = 0; i < 4; i++) send_psum(v1[i]);
      for (int i = 4; i < MAC_NUM; i++) send_psum(0);
      wait_valid(ok);
      total_cnt++;
      if (bus.out_vec[0] !== 8'sd1 || !ok) $display("FAIL shift40_pos: got %0d ok=%b expected 1", bus.out_vec[0], ok);
      else pass_cnt++;
      total_cnt++;
      if (bus.out_vec[1] !== -8'sd1) $display("FAIL shift40_neg: got %0d expected -1", bus.out_vec[1]);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL shift40_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      accept();
   endtask

   task automatic test_hold_back_to_back();
      logic signed [BW_ACT-1:0] held [MAC_NUM];
      logic signed [BW_ACT-1:0] e;
      bit ok;
      do_start(3);
      for (int i = 0; i < MAC_NUM; i++) send_psum(longint'(i * 10 - 40));
      wait_valid(ok);
      total_cnt++;
      if (!ok) $display("FAIL hold_timeout: got no out_valid expected out_valid");
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         held[i] = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== held[i]) $display("FAIL hold_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], held[i]);
         else pass_cnt++;
      end
      for (int c = 0; c < 20; c++) begin
         bus.psum_valid = c[0];
         bus.psum_in    = BW_ACCU'($urandom);
         tick();
         total_cnt++;
         if (bus.out_valid !== 1'b1) $display("FAIL hold_valid_c%0d: got %b expected 1", c, bus.out_valid);
         else pass_cnt++;
      end
      bus.psum_valid = 1'b0;
      for (int i = 0; i < MAC_NUM; i++) begin
         total_cnt++;
         if (bus.out_vec[i] !== held[i]) $display("FAIL hold_frozen[%0d]: got %0d expected %0d", i, bus.out_vec[i], held[i]);
         else pass_cnt++;
      end
      bus.out_ready = 1'b1; bus.start = 1'b1; bus.shift_num = 8'd2;
      tick();
      bus.out_ready = 1'b0; bus.start = 1'b0;
      cur_shift = 2; exp_sat = 1'b0;
      total_cnt++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL b2b_state: got busy=%b valid=%b expected 1/0", bus.busy, bus.out_valid);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) send_psum(longint'(50 - i * 11));
      wait_valid(ok);
      total_cnt++;
      if (!ok) $display("FAIL b2b_timeout: got no out_valid expected out_valid");
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL b2b_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      accept();
   endtask

   task automatic test_gaps();
      logic signed [BW_ACT-1:0] e;
      bit ok;
      do_start(1);
      for (int i = 0; i < MAC_NUM; i++) begin
         send_psum(longint'(i * 7 - 30));
         tick();
      end
      wait_valid(ok);
      total_cnt++;
      if (!ok) $display("FAIL gaps_timeout: got no out_valid expected out_valid");
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL gaps_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      accept();
   endtask

   task automatic test_mid_reset();
      logic signed [BW_ACT-1:0] e;
      bit ok;
      do_start(2);
      for (int i = 0; i < 4; i++) send_psum(longint'(1000 + i));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      total_cnt++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sat_flag !== 1'b0)
         $display("FAIL midrst_ctrl: got valid=%b busy=%b sat=%b expected 0/0/0", bus.out_valid, bus.busy, bus.sat_flag);
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         total_cnt++;
         if (bus.out_vec[i] !== '0) $display("FAIL midrst_vec[%0d]: got %0d expected 0", i, bus.out_vec[i]);
         else pass_cnt++;
      end
      bus.psum_valid = 1'b1; bus.psum_in = 32'sd1000;
      tick();
      bus.psum_valid = 1'b0;
      total_cnt++;
      if (bus.busy !== 1'b0 || bus.out_vec[0] !== '0)
         $display("FAIL idle_ignores_psum: got busy=%b vec0=%0d expected 0/0", bus.busy, bus.out_vec[0]);
      else pass_cnt++;
      do_start(2);
      for (int i = 0; i < MAC_NUM; i++) send_psum(longint'(i * 13 - 60));
      wait_valid(ok);
      total_cnt++;
      if (!ok) $display("FAIL midrst_timeout: got no out_valid expected out_valid");
      else pass_cnt++;
      for (int i = 0; i < MAC_NUM; i++) begin
         e = sb.pop_front();
         total_cnt++;
         if (bus.out_vec[i] !== e) $display("FAIL midrst_sb[%0d]: got %0d expected %0d", i, bus.out_vec[i], e);
         else pass_cnt++;
      end
      accept();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_shift_edges();
      test_hold_back_to_back();
      test_gaps();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
